// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: FSM encoding,
// default widths and requester IDs.
package regfile_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ0_ID = 1'b0;
   localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// One requester's request/response handshake bundle; the arbiter takes two.
// master = requester side, slave = arbiter side.
interface regfile_port_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-input grant logic. Round-robin on a 1-bit last_grant by default;
// REGFILE_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module rr_arbiter2
   import regfile_arb_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       grant_id,
   output logic       any_valid
);

   assign any_valid = |valid;

`ifdef REGFILE_ARB_FIXED_PRIO_EN

   always_comb begin
      grant_id = valid[0] ? REQ0_ID : REQ1_ID;
   end

`else

   logic last_grant;

   // Reset to requester 1 so requester 0 wins the first contention.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant <= REQ1_ID;
      end else if (accept) begin
         last_grant <= grant_id;
      end
   end

   always_comb begin
      grant_id = REQ0_ID;
      if (valid == 2'b11) begin
         grant_id = ~last_grant;
      end else if (valid[1]) begin
         grant_id = REQ1_ID;
      end
   end

`endif

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and Read1 between two requesters,
// one access at a time via IDLE -> ACCESS -> RESP. See rr_arbiter2 for
// the REGFILE_ARB_FIXED_PRIO_EN option.
module regfile_port_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
)(
   input  logic              clock,
   input  logic              reset,
   regfile_port_arbiter_if.slave port0,
   regfile_port_arbiter_if.slave port1,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we
);

   state_t            state_q;
   state_t            state_d;

   logic              lat_write;
   logic              lat_id;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rsp_data_q;

   logic              grant_id;
   logic              any_valid;
   logic              accept;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_rsp_ready;

   assign accept = (state_q == IDLE) && any_valid;

   rr_arbiter2 u_arb (
      .clock     (clock),
      .reset     (reset),
      .valid     ({port1.req_valid, port0.req_valid}),
      .accept    (accept),
      .grant_id  (grant_id),
      .any_valid (any_valid)
   );

   always_comb begin
      sel_write = port0.req_write;
      sel_addr  = port0.req_addr;
      sel_wdata = port0.req_wdata;
      if (grant_id == REQ1_ID) begin
         sel_write = port1.req_write;
         sel_addr  = port1.req_addr;
         sel_wdata = port1.req_wdata;
      end
   end

   always_comb begin
      sel_rsp_ready = (lat_id == REQ1_ID) ? port1.rsp_ready : port0.rsp_ready;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (sel_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch and response register. The response captures the
   // pre-write value because the register file updates on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         lat_write  <= 1'b0;
         lat_id     <= REQ0_ID;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rsp_data_q <= '0;
      end else begin
         if (accept) begin
            lat_write <= sel_write;
            lat_id    <= grant_id;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
         end
         if (state_q == ACCESS) begin
            rsp_data_q <= rf_rdata;
         end
      end
   end

   // Output logic
   always_comb begin
      port0.req_ready = accept && (grant_id == REQ0_ID);
      port1.req_ready = accept && (grant_id == REQ1_ID);
      port0.rsp_valid = (state_q == RESP) && (lat_id == REQ0_ID);
      port1.rsp_valid = (state_q == RESP) && (lat_id == REQ1_ID);
      port0.rsp_rdata = rsp_data_q;
      port1.rsp_rdata = rsp_data_q;
      rf_raddr        = lat_addr;
      rf_waddr        = lat_addr;
      rf_wdata        = lat_wdata;
      rf_we           = (state_q == ACCESS) && lat_write && (lat_addr != '0);
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a register-file model and a
// response scoreboard fed at request acceptance.
module tb_regfile_port_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 32;

   typedef struct packed {
      logic          id;
      logic [DW-1:0] data;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          rf_we;

   logic [DW-1:0] rf_mem   [64];
   logic [DW-1:0] ref_regs [64];
   exp_t          sb[$];

   int total = 0;
   int bad   = 0;

   regfile_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   regfile_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

   regfile_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock    (clock),
      .reset    (reset),
      .port0    (if0),
      .port1    (if1),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rf_we    (rf_we)
   );

   always #5 clock = ~clock;

   // Register file environment: combinational read, write on the edge.
   assign rf_rdata = rf_mem[rf_raddr];
   always @(posedge clock) begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.id   = id;
      e.data = ref_regs[a];
      sb.push_back(e);
      if (w && a != '0) ref_regs[a] = d;
   endtask

   task automatic pop_chk(input logic id, input logic [DW-1:0] data);
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rsp_id", 32'(id), 32'(e.id));
         chk("rsp_data", data, e.data);
      end
   endtask

   // Drive one request on the given port; returns at T+1 (posedge+1).
   task automatic send(input logic id, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit expect_rsp);
      bit got;
      got = 1'b0;
      if (id == 1'b0) begin
         if0.req_write = w; if0.req_addr = a; if0.req_wdata = d; if0.req_valid = 1'b1;
      end else begin
         if1.req_write = w; if1.req_addr = a; if1.req_wdata = d; if1.req_valid = 1'b1;
      end
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clock);
         if ((id == 1'b0 && if0.req_ready) || (id == 1'b1 && if1.req_ready)) begin
            got = 1'b1;
            chk("other_ready_low", 32'(id == 1'b0 ? if1.req_ready : if0.req_ready), 32'd0);
            if (expect_rsp) push_exp(id, w, a, d);
         end
      end
      chk("send_accepted", 32'(got), 32'd1);
      tick();
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 40 && sb.size() > 0; n++) tick();
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Response monitor and address-0 write guard.
   always @(negedge clock) begin
      if (!reset) begin
         if (if0.rsp_valid && if0.rsp_ready) pop_chk(1'b0, if0.rsp_rdata);
         if (if1.rsp_valid && if1.rsp_ready) pop_chk(1'b1, if1.rsp_rdata);
         if (rf_we) chk("we_addr_nonzero", 32'(rf_waddr != '0), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int ngr;
      int last_cyc;
      logic exp_last;
      logic exp_gid;
      logic gid;
      bit seen;

      for (int i = 0; i < 64; i++) begin
         rf_mem[i]   = '0;
         ref_regs[i] = '0;
      end
      if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
      if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
      if0.rsp_ready = 1'b1;
      if1.rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_req0_ready", 32'(if0.req_ready), 32'd0);
      chk("rst_req1_ready", 32'(if1.req_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(if0.rsp_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(if1.rsp_valid), 32'd0);
      chk("rst_rsp0_rdata", if0.rsp_rdata, 32'd0);
      chk("rst_rsp1_rdata", if1.rsp_rdata, 32'd0);
      chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      tick();

      // req0 writes reg 3: ACCESS timing then old value returned
      send(1'b0, 1'b1, 6'd3, 32'hABCDEFFF, 1'b1);
      @(negedge clock);
      chk("wr_t1_we", 32'(rf_we), 32'd1);
      chk("wr_t1_waddr", 32'(rf_waddr), 32'd3);
      chk("wr_t1_wdata", rf_wdata, 32'hABCDEFFF);
      chk("wr_t1_raddr", 32'(rf_raddr), 32'd3);
      chk("wr_t1_rsp0_valid", 32'(if0.rsp_valid), 32'd0);
      @(negedge clock);
      chk("wr_t2_rsp0_valid", 32'(if0.rsp_valid), 32'd1);
      chk("wr_t2_we", 32'(rf_we), 32'd0);
      tick();
      wait_drain();

      // req1 reads reg 3
      send(1'b1, 1'b0, 6'd3, 32'h0, 1'b1);
      @(negedge clock);
      chk("rd_t1_we", 32'(rf_we), 32'd0);
      @(negedge clock);
      chk("rd_t2_rsp1_valid", 32'(if1.rsp_valid), 32'd1);
      chk("rd_t2_we", 32'(rf_we), 32'd0);
      tick();
      wait_drain();

      // Continuous contention, rsp_ready tied high
      if0.req_write = 1'b0; if0.req_addr = 6'd3; if0.req_valid = 1'b1;
      if1.req_write = 1'b0; if1.req_addr = 6'd7; if1.req_valid = 1'b1;
      ngr = 0;
      last_cyc = -1;
      exp_last = 1'b1;
      for (int c = 0; c < 30 && ngr < 4; c++) begin
         @(negedge clock);
         if (if0.req_ready || if1.req_ready) begin
            gid = if1.req_ready;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            exp_gid = 1'b0;
`else
            exp_gid = ~exp_last;
`endif
            chk("cont_grant", 32'(gid), 32'(exp_gid));
            chk("cont_one_ready", 32'(if0.req_ready & if1.req_ready), 32'd0);
            if (last_cyc >= 0) chk("cont_interval", 32'(c - last_cyc), 32'd3);
            push_exp(gid, 1'b0, gid ? 6'd7 : 6'd3, 32'h0);
            exp_last = gid;
            last_cyc = c;
            ngr++;
         end
         tick();
      end
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      chk("cont_count", 32'(ngr), 32'd4);
      wait_drain();

      // Write to reg 0 is answered but never reaches the register file
      send(1'b0, 1'b1, 6'd0, 32'hFBCDE111, 1'b1);
      @(negedge clock);
      chk("wr0_we", 32'(rf_we), 32'd0);
      tick();
      wait_drain();
      send(1'b1, 1'b0, 6'd0, 32'h0, 1'b1);
      wait_drain();

      // Response backpressure on port 0 with req1 pending
      if0.rsp_ready = 1'b0;
      send(1'b0, 1'b0, 6'd3, 32'h0, 1'b1);
      if1.req_write = 1'b0; if1.req_addr = 6'd3; if1.req_valid = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clock);
         if (if0.rsp_valid) seen = 1'b1;
         else chk("bp_wait_req1_ready", 32'(if1.req_ready), 32'd0);
      end
      chk("bp_rsp_seen", 32'(seen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp0_valid", 32'(if0.rsp_valid), 32'd1);
         chk("bp_rsp0_rdata", if0.rsp_rdata, 32'hABCDEFFF);
         chk("bp_req1_ready", 32'(if1.req_ready), 32'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1 if0.rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_req1_ready", 32'(if1.req_ready), 32'd0);
      @(negedge clock);
      chk("bp_after_req1_ready", 32'(if1.req_ready), 32'd1);
      if (if1.req_ready) push_exp(1'b1, 1'b0, 6'd3, 32'h0);
      tick();
      if1.req_valid = 1'b0;
      wait_drain();

      // Reset while in RESP discards the response; req0 wins afterwards
      if0.rsp_ready = 1'b0;
      send(1'b0, 1'b0, 6'd3, 32'h0, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clock);
         if (if0.rsp_valid) seen = 1'b1;
      end
      chk("rr_rsp_seen", 32'(seen), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if0.rsp_ready = 1'b1;
      if0.req_write = 1'b0; if0.req_addr = 6'd5; if0.req_valid = 1'b1;
      if1.req_write = 1'b0; if1.req_addr = 6'd7; if1.req_valid = 1'b1;
      @(negedge clock);
      chk("rr_rsp0_valid", 32'(if0.rsp_valid), 32'd0);
      chk("rr_rf_we", 32'(rf_we), 32'd0);
      chk("rr_req0_ready", 32'(if0.req_ready), 32'd1);
      chk("rr_req1_ready", 32'(if1.req_ready), 32'd0);
      if (if0.req_ready) push_exp(1'b0, 1'b0, 6'd5, 32'h0);
      tick();
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      wait_drain();

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
